// File: rtl/adc_pkg.sv
// Shared types and defaults for the multi-channel serial ADC receiver.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } adc_state_e;

    localparam int DEF_NCH        = 2;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_LEAD       = 4;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_CLK_DIV    = 16;
    localparam int DEF_QUIET_CYC  = 8;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV clk cycles while enabled,
// starting with a fall, and flags the cycle ending in each fall or rise.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);

    localparam int               DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             sclk_q;
    logic             sclk_d;
    logic             half_done_s;

    // Divider next state and edge ticks; disabled means parked high with count cleared.
    always_comb begin
        half_done_s = en_i && (div_q == DIV_LAST);
        fall_tick_o = half_done_s && sclk_q;
        rise_tick_o = half_done_s && !sclk_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b1;
        end else if (half_done_s) begin
            div_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            div_d  = div_q + DIV_ONE;
            sclk_d = sclk_q;
        end
    end

    // Divider and serial clock flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sclk_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Multi-channel serial ADC receiver: generates cs_n/sclk, shifts NCH lines in
// parallel, strips and checks the leading zeros, and offers results on valid/ready.
module adc_serial_rx
    import adc_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEAD       = DEF_LEAD,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int QUIET_CYC  = DEF_QUIET_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cont_en,
    input  logic [NCH-1:0]        adc_sdata,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    output logic [NCH*DATA_W-1:0] sample_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  lead_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int               BIT_W      = cnt_width(FRAME_BITS + 1);
    localparam int               QW         = cnt_width(QUIET_CYC);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_FRAME  = BIT_W'(FRAME_BITS);
    localparam logic [QW-1:0]    QUIET_ONE  = QW'(1);
    localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_CYC - 1);

    adc_state_e state_q;
    adc_state_e state_d;

    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic [QW-1:0]         quiet_q;
    logic [QW-1:0]         quiet_d;
    logic                  cs_n_q;
    logic                  cs_n_d;
    logic                  busy_q;
    logic                  busy_d;
    logic [NCH*DATA_W-1:0] data_q;
    logic [NCH*DATA_W-1:0] data_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  lead_q;
    logic                  lead_d;
    logic                  overrun_q;
    logic                  overrun_d;

    logic                  conv_en_s;
    logic                  fall_tick_s;
    logic                  rise_tick_s;
    logic                  last_rise_s;
    logic                  quiet_done_s;
    logic [NCH*DATA_W-1:0] result_s;
    logic [NCH-1:0]        ch_lead_s;

    assign conv_en_s = (state_q == CONV);

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (conv_en_s),
        .sclk_o      (adc_sclk),
        .fall_tick_o (fall_tick_s),
        .rise_tick_o (rise_tick_s)
    );

    // Falls are counted, so the rise that follows the FRAME_BITS-th fall closes the frame.
    assign last_rise_s  = rise_tick_s && (bit_q == BIT_FRAME);
    assign quiet_done_s = (state_q == QUIET) && (quiet_q == QUIET_LAST);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [FRAME_BITS-1:0] shift_q;
        logic [FRAME_BITS-1:0] shift_d;
        logic                  lead_any_s;

        // Shift in one bit per sclk rise, first bit ending up at the MSB.
        always_comb begin
            shift_d = shift_q;
            if (rise_tick_s) begin
                shift_d = (shift_q << 1) | FRAME_BITS'(adc_sdata[k]);
            end else begin
                shift_d = shift_q;
            end
        end

        // OR of the leading bits as they will stand after this cycle's shift.
        always_comb begin
            lead_any_s = 1'b0;
            for (int b = 0; b < LEAD; b++) begin
                lead_any_s = lead_any_s | shift_d[FRAME_BITS-1-b];
            end
        end

        // Per-channel shift register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q <= '0;
            end else begin
                shift_q <= shift_d;
            end
        end

        assign result_s[k*DATA_W +: DATA_W] = shift_d[FRAME_BITS-1-LEAD -: DATA_W];
        assign ch_lead_s[k]                 = lead_any_s;
    end

    // Next-state logic for the IDLE/CONV/QUIET sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start || cont_en) begin
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (last_rise_s) begin
                    state_d = QUIET;
                end else begin
                    state_d = CONV;
                end
            end
            QUIET: begin
                if (quiet_done_s) begin
                    state_d = cont_en ? CONV : IDLE;
                end else begin
                    state_d = QUIET;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters and pin-level flops; cs_n/busy are derived from the next state so they are flop outputs.
    always_comb begin
        bit_d   = bit_q;
        quiet_d = quiet_q;
        cs_n_d  = (state_d != CONV);
        busy_d  = (state_d != IDLE);
        if (conv_en_s) begin
            if (fall_tick_s) begin
                bit_d = bit_q + BIT_ONE;
            end else begin
                bit_d = bit_q;
            end
        end else begin
            bit_d = '0;
        end
        if ((state_q == QUIET) && !quiet_done_s) begin
            quiet_d = quiet_q + QUIET_ONE;
        end else begin
            quiet_d = '0;
        end
    end

    // Output register: a load always wins, and only overwrites count as overrun.
    always_comb begin
        data_d    = data_q;
        lead_d    = lead_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (last_rise_s) begin
            data_d    = result_s;
            lead_d    = |ch_lead_s;
            valid_d   = 1'b1;
            overrun_d = valid_q && !sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // All state and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            quiet_q   <= '0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            lead_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            quiet_q   <= quiet_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            lead_q    <= lead_d;
            overrun_q <= overrun_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign busy         = busy_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign lead_err     = lead_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: a converter model feeds frames, a reference model
// predicts each result into a queue, and a monitor checks every handshake.
module tb_adc_serial_rx;

    localparam int NCH        = 2;
    localparam int DATA_W     = 12;
    localparam int LEAD       = 4;
    localparam int FRAME_BITS = 16;
    localparam int CLK_DIV    = 2;
    localparam int QUIET_CYC  = 8;
    localparam int FRAME_CYC  = 2 * FRAME_BITS * CLK_DIV;

    typedef logic [NCH-1:0][FRAME_BITS-1:0] words_t;
    typedef struct {
        logic [NCH*DATA_W-1:0] data;
        logic                  lead;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic                  cont_en = 1'b0;
    logic                  sample_ready = 1'b0;
    logic [NCH-1:0]        adc_sdata = '0;
    logic                  adc_cs_n;
    logic                  adc_sclk;
    logic [NCH*DATA_W-1:0] sample_data;
    logic                  sample_valid;
    logic                  lead_err;
    logic                  overrun;
    logic                  busy;

    int     tests = 0;
    int     fails = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;
    words_t next_words = '0;
    words_t cur_words = '0;
    bit     rand_words = 1'b0;
    int     bit_idx = 0;

    int   cyc = 0;
    int   low_run = 0;
    int   rise_run = 0;
    int   frames_done = 0;
    int   last_low = 0;
    int   last_rises = 0;
    int   ov_cnt = 0;
    int   valid_cyc = 0;
    logic valid_at_end = 1'b0;
    logic prev_sclk = 1'b1;
    logic prev_cs = 1'b1;
    int   fall_cyc[$];
    logic [NCH*DATA_W-1:0] last_pop_data = '0;

    adc_serial_rx #(
        .NCH        (NCH),
        .DATA_W     (DATA_W),
        .LEAD       (LEAD),
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV),
        .QUIET_CYC  (QUIET_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cont_en      (cont_en),
        .adc_sdata    (adc_sdata),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .lead_err     (lead_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Result as the converter word defines it: leading bits on top, then the data field.
    function automatic exp_t model(input words_t w);
        exp_t                  e;
        logic [FRAME_BITS-1:0] field;
        e.data = '0;
        e.lead = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            field = w[k] >> (FRAME_BITS - LEAD - DATA_W);
            e.data[k*DATA_W +: DATA_W] = field[DATA_W-1:0];
            e.lead = e.lead | ((w[k] >> (FRAME_BITS - LEAD)) != '0);
        end
        return e;
    endfunction

    function automatic logic [FRAME_BITS-1:0] rand_word();
        logic [FRAME_BITS-1:0] w;
        int                    idx;
        w = FRAME_BITS'($urandom) & ((FRAME_BITS'(1) << (FRAME_BITS - LEAD)) - FRAME_BITS'(1));
        if ($urandom_range(0, 3) == 0) begin
            idx = FRAME_BITS - 1 - int'($urandom_range(0, LEAD - 1));
            w[idx] = 1'b1;
        end
        return w;
    endfunction

    // Converter: picks a frame at cs_n fall and launches one bit per sclk fall.
    always @(negedge adc_cs_n) begin
        if (rst_n === 1'b1) begin
            for (int k = 0; k < NCH; k++) begin
                cur_words[k] = rand_words ? rand_word() : next_words[k];
            end
            bit_idx = 0;
            exp_q.push_back(model(cur_words));
        end
    end

    always @(negedge adc_sclk) begin
        if (adc_cs_n === 1'b0 && bit_idx < FRAME_BITS) begin
            for (int k = 0; k < NCH; k++) begin
                adc_sdata[k] = cur_words[k][FRAME_BITS-1-bit_idx];
            end
            bit_idx++;
        end
    end

    // Monitor: frame geometry bookkeeping plus scoreboard pops on overrun and handshake.
    always @(negedge clk) begin
        cyc++;
        if (rst_n !== 1'b1) begin
            low_run   = 0;
            rise_run  = 0;
            prev_sclk = 1'b1;
            prev_cs   = 1'b1;
        end else begin
            if (prev_cs == 1'b0 && prev_sclk == 1'b0 && adc_sclk == 1'b1) rise_run++;
            if (adc_cs_n == 1'b0) begin
                if (low_run == 0) fall_cyc.push_back(cyc);
                low_run++;
            end else if (low_run != 0) begin
                last_low     = low_run;
                last_rises   = rise_run;
                valid_at_end = sample_valid;
                frames_done++;
                low_run  = 0;
                rise_run = 0;
            end
            if (sample_valid) valid_cyc++;
            if (overrun) begin
                ov_cnt++;
                check("overrun_has_victim", 64'(exp_q.size() >= 2), 64'd1);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL handshake: actual data=%0h required no result", sample_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sample_data", 64'(sample_data), 64'(mon_e.data));
                    check("lead_err", 64'(lead_err), 64'(mon_e.lead));
                    last_pop_data = sample_data;
                end
            end
            prev_sclk = adc_sclk;
            prev_cs   = adc_cs_n;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input bit chk);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (chk) begin
            check("cs_n_low_after_start", 64'(adc_cs_n), 64'd0);
            check("busy_after_start", 64'(busy), 64'd1);
            tick(CLK_DIV - 1);
            check("sclk_high_before_fall", 64'(adc_sclk), 64'd1);
            tick(1);
            check("sclk_first_fall", 64'(adc_sclk), 64'd0);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_in_time", 64'(frames_done >= target), 64'd1);
    endtask

    initial begin
        int base;
        int ovb;
        int nfall;
        int vlow;
        int n;

        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ovb;
        int nfall;
        int vlow;
        int n;

        #2 rst_n = 1'b0;
        #1;
        check("rst_cs_n", 64'(adc_cs_n), 64'd1);
        check("rst_sclk", 64'(adc_sclk), 64'd1);
        check("rst_data", 64'(sample_data), 64'd0);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_lead_err", 64'(lead_err), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single shot with fixed words.
        next_words[0] = 16'h0ABC;
        next_words[1] = 16'h0123;
        sample_ready  = 1'b1;
        valid_cyc     = 0;
        base          = frames_done;
        pulse_start(1'b1);
        wait_frames(base + 1, FRAME_CYC + 20);
        check("single_cs_low_cycles", 64'(last_low), 64'(FRAME_CYC));
        check("single_sclk_rises", 64'(last_rises), 64'(FRAME_BITS));
        check("single_valid_at_cs_rise", 64'(valid_at_end), 64'd1);
        tick(QUIET_CYC + 2);
        check("single_valid_one_cycle", 64'(valid_cyc), 64'd1);
        check("single_data", 64'(last_pop_data), 64'h123ABC);
        check("single_busy_after_quiet", 64'(busy), 64'd0);

        // Framing error on channel 1.
        next_words[0] = 16'h0555;
        next_words[1] = 16'h8FFF;
        base          = frames_done;
        pulse_start(1'b0);
        wait_frames(base + 1, FRAME_CYC + 20);
        tick(2);
        check("framing_ch1_data", 64'(last_pop_data[23:12]), 64'hFFF);
        check("framing_lead_err", 64'(lead_err), 64'd1);
        tick(QUIET_CYC + 2);

        // Random single shots with random backpressure.
        rand_words = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample_ready = 1'($urandom_range(0, 1));
            base         = frames_done;
            pulse_start(1'b0);
            wait_frames(base + 1, FRAME_CYC + 20);
            tick(QUIET_CYC + 2);
        end
        sample_ready = 1'b1;
        tick(2);

        // Continuous mode with the consumer stalled for three frames.
        sample_ready = 1'b0;
        base         = frames_done;
        ovb          = ov_cnt;
        nfall        = fall_cyc.size();
        cont_en      = 1'b1;
        wait_frames(base + 1, FRAME_CYC + 20);
        vlow = 0;
        n    = 0;
        while (frames_done < base + 3 && n < 3 * FRAME_CYC) begin
            @(negedge clk);
            if (!sample_valid) vlow++;
            n++;
        end
        cont_en = 1'b0;
        check("cont_three_frames", 64'(frames_done), 64'(base + 3));
        check("cont_valid_held", 64'(vlow), 64'd0);
        check("cont_overrun_count", 64'(ov_cnt - ovb), 64'd2);
        if (fall_cyc.size() >= nfall + 3) begin
            check("cont_period_1", 64'(fall_cyc[nfall+1] - fall_cyc[nfall]), 64'(FRAME_CYC + QUIET_CYC));
            check("cont_period_2", 64'(fall_cyc[nfall+2] - fall_cyc[nfall+1]), 64'(FRAME_CYC + QUIET_CYC));
        end else begin
            check("cont_fall_count", 64'(fall_cyc.size() - nfall), 64'd3);
        end
        check("cont_one_result_pending", 64'(exp_q.size()), 64'd1);
        tick(QUIET_CYC + 4);
        check("cont_stop_no_extra_frame", 64'(frames_done), 64'(base + 3));
        check("cont_stop_idle", 64'(busy), 64'd0);
        sample_ready = 1'b1;
        tick(2);
        check("cont_drained_valid", 64'(sample_valid), 64'd0);
        check("cont_drained_queue", 64'(exp_q.size()), 64'd0);

        // Handshake in the same cycle as a load.
        sample_ready = 1'b0;
        base         = frames_done;
        pulse_start(1'b0);
        wait_frames(base + 1, FRAME_CYC + 20);
        tick(QUIET_CYC + 2);
        ovb = ov_cnt;
        pulse_start(1'b0);
        tick(FRAME_CYC - 1);
        sample_ready = 1'b1;
        tick(1);
        sample_ready = 1'b0;
        check("simul_load_cs_high", 64'(adc_cs_n), 64'd1);
        check("simul_no_overrun", 64'(overrun), 64'd0);
        check("simul_valid_kept", 64'(sample_valid), 64'd1);
        tick(2);
        check("simul_overrun_total", 64'(ov_cnt - ovb), 64'd0);
        check("simul_new_pending", 64'(exp_q.size()), 64'd1);
        sample_ready = 1'b1;
        tick(QUIET_CYC + 2);

        // start while busy must not queue a second frame.
        base = frames_done;
        pulse_start(1'b0);
        tick(10);
        start = 1'b1;
        tick(3);
        start = 1'b0;
        tick(30);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_frames(base + 1, FRAME_CYC + 20);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(QUIET_CYC + FRAME_CYC);
        check("busy_start_one_frame", 64'(frames_done), 64'(base + 1));
        check("busy_start_idle", 64'(busy), 64'd0);

        // cont_en dropped mid-frame finishes that frame only.
        base    = frames_done;
        cont_en = 1'b1;
        tick(21);
        cont_en = 1'b0;
        wait_frames(base + 1, FRAME_CYC + 20);
        tick(QUIET_CYC + FRAME_CYC);
        check("cont_drop_one_frame", 64'(frames_done), 64'(base + 1));
        check("cont_drop_idle", 64'(busy), 64'd0);
        check("cont_drop_cs_high", 64'(adc_cs_n), 64'd1);

        // Reset in the middle of a frame, with an unconsumed result held.
        sample_ready = 1'b0;
        base         = frames_done;
        pulse_start(1'b0);
        wait_frames(base + 1, FRAME_CYC + 20);
        tick(QUIET_CYC + 2);
        pulse_start(1'b0);
        n = 0;
        while (rise_run < 7 && n < FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check("reached_rise_7", 64'(rise_run), 64'd7);
        check("valid_before_reset", 64'(sample_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 64'(adc_cs_n), 64'd1);
        check("midrst_sclk", 64'(adc_sclk), 64'd1);
        check("midrst_valid", 64'(sample_valid), 64'd0);
        check("midrst_data", 64'(sample_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        rand_words    = 1'b0;
        next_words[0] = 16'h0F5A;
        next_words[1] = 16'h0E71;
        sample_ready  = 1'b1;
        base          = frames_done;
        pulse_start(1'b1);
        wait_frames(base + 1, FRAME_CYC + 20);
        check("post_rst_cs_low_cycles", 64'(last_low), 64'(FRAME_CYC));
        check("post_rst_sclk_rises", 64'(last_rises), 64'(FRAME_BITS));
        tick(2);
        check("post_rst_data", 64'(last_pop_data), 64'hE71F5A);

        tick(QUIET_CYC + 4);
        check("all_results_consumed", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
